instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, encoded-word buffer depth (power of 2, >=2).
REQ-002 Parameter: ADDR_W, default 10, instruction-memory address width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: start  input  1  single-cycle pulse; loads base_addr and begins a program load.
REQ-006 Port: base_addr  input  ADDR_W  first instruction-memory address written.
REQ-007 Port: in_valid / in_ready  input / output  1 / 1  field handshake; a transfer occurs when both are high on a clk edge.
REQ-008 Port: in_opcode  input  6  operation code, legal range 0..32.
REQ-009 Port: in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-010 Port: in_imm  input  26  immediate or jump target; low 16 bits used for I-format.
REQ-011 Port: in_last  input  1  marks the final instruction of the program; sampled with the transfer.
REQ-012 Port: mem_we  output  1  instruction-memory write request.
REQ-013 Port: mem_addr / mem_wdata  output  ADDR_W / 32  write address and encoded instruction word.
REQ-014 Port: mem_ready  input  1  memory accepts the write on this edge.
REQ-015 Port: busy / done  output  1 / 1  load in progress / one-cycle completion pulse.
REQ-016 Port: err_illegal  output  1  one-cycle pulse when an accepted opcode is >32.
REQ-017 Port: count  output  ADDR_W+1  number of words written since the last start.

Function
REQ-018 Encoding SHALL be: R-format, opcodes 0,2,4,...,16,18,19,26,30 -> {op[5:0], rs, rt, rd, 11'b0}.
REQ-019 Encoding SHALL be: J-format, opcodes 22..25, 28, 29 -> {op, in_imm[25:0]}.
REQ-020 Encoding SHALL be: I-format, all other legal opcodes -> {op, rs, rt, in_imm[15:0]}.
REQ-021 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-022 IDLE: in_ready=0; start -> RUN, with mem_addr<=base_addr and count<=0.
REQ-023 RUN: in_ready = !fifo_full; a transfer with in_last=1 -> DRAIN.
REQ-024 DRAIN: in_ready=0; when the FIFO is empty and no write is pending -> DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 An accepted legal instruction SHALL be pushed to the FIFO; mem_we SHALL be high earliest on the cycle after acceptance (1-cycle latency).
REQ-028 An illegal opcode SHALL NOT be pushed and SHALL pulse err_illegal on the next cycle; if in_last=1 accompanies it, the transition to DRAIN still occurs.
REQ-029 mem_we = FIFO not empty; mem_wdata = FIFO head; mem_addr/mem_wdata SHALL be held stable while mem_we=1 and mem_ready=0.
REQ-030 On mem_we && mem_ready: pop the FIFO, mem_addr+1 (wraps from 2^ADDR_W-1 to 0), count+1.
REQ-031 in_ready SHALL be low when the FIFO is full, even if a pop occurs the same cycle (no full-bypass); simultaneous push and pop when not full SHALL keep occupancy unchanged.
REQ-032 busy SHALL be 1 in RUN and DRAIN, 0 otherwise.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, empty the FIFO, and clear all outputs to 0 (in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_illegal, count), including mid-load; no write may be issued after reset assertion.

Verification
REQ-034 base_addr=0x010, start; single transfer op=1, rs=2, rt=3, imm=0x0005, last=1, mem_ready=1 -> mem_we next cycle, mem_addr=0x010, mem_wdata=0x04430005, done pulse, count=1.
REQ-035 R-format op=0, rs=1, rt=2, rd=3 -> mem_wdata=0x00221800; J-format op=22, imm=0x0000040 -> 0x58000040.
REQ-036 mem_ready=0 with 5 back-to-back transfers -> in_ready drops after 4 accepts; mem_addr/mem_wdata stable; release mem_ready -> 5 writes at consecutive addresses, count=5.
REQ-037 op=40 with last=1 -> err_illegal one pulse, no write, DRAIN->DONE, count=0.
REQ-038 base_addr=0x3FF, two instructions -> writes at 0x3FF then 0x000.
REQ-039 Assert rst_n low with 3 words buffered -> mem_we=0 and all outputs 0 asynchronously; after release, FSM is IDLE and in_ready=0.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Accepts decoded instruction fields over a valid/ready handshake, packs each
// legal instruction into a 32-bit R/I/J-format word, buffers the words in a
// small FIFO and streams them into instruction memory at consecutive addresses
// starting from base_addr.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, base_addr      begin a program load at base_addr (honoured in IDLE)
//   in_valid / in_ready   field handshake; transfer when both high on an edge
//   in_opcode, in_rs, in_rt, in_rd, in_imm, in_last
//                         instruction fields; in_last marks the final one
//   mem_we, mem_addr, mem_wdata, mem_ready
//                         memory write port; a write completes on
//                         mem_we && mem_ready
//   busy, done            load in progress / one-cycle completion pulse
//   err_illegal           one-cycle pulse after an accepted opcode > 32
//   count                 words written since the last start
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W:0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;

  // FIFO pointers carry one extra wrap bit so full and empty are distinct.
  logic [31:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           fifo_empty;
  logic           fifo_full;

  logic        op_legal;
  logic [31:0] enc_word;
  logic        accept;
  logic        push;
  logic        pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // in_ready looks only at fullness, never at a same-cycle pop.
  assign in_ready = (state == RUN) && !fifo_full;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  assign mem_we    = !fifo_empty;
  // Storage is not reset, so the head is masked to keep mem_wdata at 0
  // whenever nothing is queued (including straight after reset).
  assign mem_wdata = fifo_empty ? 32'd0 : fifo_mem[rd_ptr[PTR_W-1:0]];

  assign op_legal = (in_opcode <= 6'd32);
  assign accept   = in_valid && in_ready;
  assign push     = accept && op_legal;
  assign pop      = mem_we && mem_ready;

  // Format selection: R and J opcodes are listed explicitly, every other
  // opcode uses the I-format layout.
  always_comb begin
    // NOTE: default assignment first so every path drives enc_word; without
    // it the unlisted opcodes would infer a latch.
    enc_word = {in_opcode, in_rs, in_rt, in_imm[15:0]};
    case (in_opcode)
      6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd10, 6'd12, 6'd14, 6'd16,
      6'd18, 6'd19, 6'd26, 6'd30:
        enc_word = {in_opcode, in_rs, in_rt, in_rd, 11'b0};
      6'd22, 6'd23, 6'd24, 6'd25, 6'd28, 6'd29:
        enc_word = {in_opcode, in_imm[25:0]};
      default: ;
    endcase
  end

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        // An illegal final instruction still ends the stream.
        RUN:     if (accept && in_last) state <= DRAIN;
        // Empty FIFO means mem_we is low, so no write is outstanding.
        DRAIN:   if (fifo_empty) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write address, word count and illegal-opcode pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr    <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept && !op_legal;
      if (state == IDLE && start) begin
        mem_addr <= base_addr;
        count    <= '0;
      end else if (pop) begin
        // Natural ADDR_W-bit overflow gives the wrap to address 0.
        mem_addr <= mem_addr + ADDR_W'(1);
        count    <= count + (ADDR_W + 1)'(1);
      end
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
  end

endmodule
